accum_calc: RTL and testbench

Parametrised successor to the fixed 32-bit limited-function calculator. A sequential controller fetches one instruction per two cycles from an external synchronous instruction memory. It executes add/subtract/load/clear operations on sign-extended immediates and a WIDTH-bit accumulator, and stops on a HALT opcode or program-end wrap. It adds a start/done handshake, sticky overflow and zero flags, and an optional saturating mode.

---
 rtl/accum_calc_pkg.sv | 36 +++
 rtl/accum_calc_alu.sv | 60 ++++++
 rtl/accum_calc.sv | 135 +++++++++++++
 tb/tb_accum_calc.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_calc_pkg.sv
// Shared types and instruction-field helpers for the accumulator calculator.
// Instruction word layout, MSB first: {funct[2:0], immA[IMM_W-1:0], immB[IMM_W-1:0]}.
package accum_calc_pkg;

  typedef enum logic [2:0] {
    F_ADD     = 3'b000,
    F_SUB     = 3'b001,
    F_ACC_ADD = 3'b010,
    F_ACC_SUB = 3'b011,
    F_LOAD    = 3'b100,
    F_CLR     = 3'b101,
    F_NOP     = 3'b110,
    F_HALT    = 3'b111
  } funct_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  localparam int FUNCT_W = 3;

  function automatic int instr_w(input int imm_w);
    return FUNCT_W + 2 * imm_w;
  endfunction

  function automatic int funct_lsb(input int imm_w);
    return 2 * imm_w;
  endfunction

  function automatic int imm_a_lsb(input int imm_w);
    return imm_w;
  endfunction

endpackage

// File: rtl/accum_calc_alu.sv
// Combinational ALU: operand select, sign-extend, add/sub, signed overflow detect.
// Zero latency, no flow control. ACCUM_CALC_SAT_EN clamps overflowed results to signed max/min.
module accum_calc_alu
  import accum_calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = 14
) (
  input  logic [2:0]       funct_i,
  input  logic [IMM_W-1:0] imm_a_i,
  input  logic [IMM_W-1:0] imm_b_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o,
  output logic             wr_en_o
);

  logic [WIDTH-1:0] a_ext, b_ext, op_x, op_y, sum, plain;
  logic             sub, arith;

  assign a_ext = WIDTH'($signed(imm_a_i));
  assign b_ext = WIDTH'($signed(imm_b_i));

  always_comb begin
    op_x    = a_ext;
    op_y    = b_ext;
    sub     = 1'b0;
    arith   = 1'b0;
    wr_en_o = 1'b1;
    plain   = '0;
    case (funct_e'(funct_i))
      F_ADD:     arith = 1'b1;
      F_SUB:     begin arith = 1'b1; sub = 1'b1; end
      F_ACC_ADD: begin op_x = acc_i; op_y = a_ext; arith = 1'b1; end
      F_ACC_SUB: begin op_x = acc_i; op_y = a_ext; arith = 1'b1; sub = 1'b1; end
      F_LOAD:    plain = a_ext;
      F_CLR:     plain = '0;
      default:   begin plain = acc_i; wr_en_o = 1'b0; end
    endcase
  end

  assign sum = sub ? (op_x - op_y) : (op_x + op_y);

  // Overflow iff the effective operands share a sign and the result's sign differs.
  assign ovf_o = arith && (sum[WIDTH-1] != op_x[WIDTH-1]) &&
                 (sub ? (op_x[WIDTH-1] != op_y[WIDTH-1]) : (op_x[WIDTH-1] == op_y[WIDTH-1]));

`ifdef ACCUM_CALC_SAT_EN
  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  always_comb begin
    result_o = arith ? sum : plain;
`ifdef ACCUM_CALC_SAT_EN
    if (ovf_o) result_o = op_x[WIDTH-1] ? S_MIN : S_MAX;
`endif
  end

endmodule

// File: rtl/accum_calc.sv
// Sequential accumulator calculator: fetches from sync imem, executes, stops on HALT or PC wrap.
// 2 cycles per instruction; done pulses 2(k+1) cycles after start. No backpressure; start ignored while busy.
// Optional saturation via ACCUM_CALC_SAT_EN (handled in accum_calc_alu).
module accum_calc
  import accum_calc_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int IMM_W   = 14,
  parameter  int PC_W    = 8,
  localparam int INSTR_W = instr_w(IMM_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               imem_rd_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [WIDTH-1:0]   acc,
  output logic               zero,
  output logic               ovf,
  output logic               wrapped,
  output logic [PC_W-1:0]    pc
);

  localparam int FUNCT_LSB = funct_lsb(IMM_W);
  localparam int IMM_A_LSB = imm_a_lsb(IMM_W);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;
  logic             wrapped_q, wrapped_d, done_q, done_d;

  logic [2:0]       funct;
  logic [IMM_W-1:0] imm_a, imm_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf, alu_wr;

  assign funct = imem_data[FUNCT_LSB +: FUNCT_W];
  assign imm_a = imem_data[IMM_A_LSB +: IMM_W];
  assign imm_b = imem_data[IMM_W-1:0];

  accum_calc_alu #(.WIDTH(WIDTH), .IMM_W(IMM_W)) u_alu (
    .funct_i  (funct),
    .imm_a_i  (imm_a),
    .imm_b_i  (imm_b),
    .acc_i    (acc_q),
    .result_o (alu_res),
    .ovf_o    (alu_ovf),
    .wr_en_o  (alu_wr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      acc_q     <= '0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
      wrapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      wrapped_q <= wrapped_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    acc_d      = acc_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    wrapped_d  = wrapped_q;
    done_d     = 1'b0;
    busy       = 1'b0;
    imem_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FETCH;
          pc_d      = '0;
          acc_d     = '0;
          zero_d    = 1'b1;
          ovf_d     = 1'b0;
          wrapped_d = 1'b0;
        end
      end
      ST_FETCH: begin
        busy       = 1'b1;
        imem_rd_en = 1'b1;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        busy = 1'b1;
        if (funct == F_HALT) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (alu_wr) begin
            acc_d  = alu_res;
            zero_d = (alu_res == '0);
            ovf_d  = ovf_q | alu_ovf;
          end
          pc_d = pc_q + 1'b1;
          // Last word executed without HALT: pc rolls to 0 and the run ends.
          if (pc_q == '1) begin
            wrapped_d = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done      = done_q;
  assign imem_addr = pc_q;
  assign acc       = acc_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign wrapped   = wrapped_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_accum_calc.sv
// Bench for accum_calc: program-level reference model, per-cycle compare, directed + random programs.
module tb_accum_calc;

  localparam int W = 16, IW = 14, PW = 3, D = 8, IRW = 3 + 2 * IW;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));
  localparam longint MODV = longint'(1) <<< W;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AADD = 3'd2, OP_ASUB = 3'd3;
  localparam logic [2:0] OP_LOAD = 3'd4, OP_CLR = 3'd5, OP_NOP = 3'd6, OP_HALT = 3'd7;
`ifdef ACCUM_CALC_SAT_EN
  localparam logic [W-1:0] OVF_PROG_ACC = 16'h7FFF;
`else
  localparam logic [W-1:0] OVF_PROG_ACC = 16'h9FFB;  // 40955 - 65536 = -24581
`endif

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic busy, done, imem_rd_en, zero, ovf, wrapped;
  logic [PW-1:0] imem_addr, pc;
  logic [IRW-1:0] imem_data = '0;
  logic [W-1:0] acc;
  logic [IRW-1:0] imem [D];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  accum_calc #(.WIDTH(W), .IMM_W(IW), .PC_W(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .acc(acc), .zero(zero), .ovf(ovf), .wrapped(wrapped), .pc(pc)
  );

  always @(posedge clk) if (imem_rd_en) imem_data <= imem[imem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [IRW-1:0] mk(input logic [2:0] f, input int a, input int b);
    return {f, IW'(a), IW'(b)};
  endfunction

  function automatic longint sx(input logic [IW-1:0] v);
    return longint'($signed(v));
  endfunction

  // Reference model: whole program evaluated with exact integers when a run starts.
  bit m_run = 0, m_done = 0;
  int m_t = 0, m_end_t = 0;
  logic [W-1:0] r_acc [D];
  bit r_ovf [D];
  logic [W-1:0] fin_acc = '0, idle_acc = '0;
  bit fin_ovf = 0, idle_ovf = 0, fin_wrap = 0, idle_wrap = 0;
  logic [PW-1:0] fin_pc = '0, idle_pc = '0;

  task automatic model_program();
    longint a_l, x, y, ex;
    logic [2:0] f;
    bit ov;
    a_l = 0; ov = 0;
    m_end_t = 2 * D; fin_pc = '0; fin_wrap = 1;
    for (int i = 0; i < D; i++) begin
      f = imem[i][IRW-1 -: 3];
      x = sx(imem[i][2*IW-1 -: IW]);
      y = sx(imem[i][IW-1:0]);
      if (f == OP_HALT) begin
        m_end_t = 2 * i + 2; fin_pc = PW'(i); fin_wrap = 0;
        break;
      end
      case (f)
        OP_ADD:  ex = x + y;
        OP_SUB:  ex = x - y;
        OP_AADD: ex = a_l + x;
        OP_ASUB: ex = a_l - x;
        OP_LOAD: ex = x;
        OP_CLR:  ex = 0;
        default: ex = a_l;
      endcase
      if (ex > MAXV) begin
        ov = 1;
`ifdef ACCUM_CALC_SAT_EN
        ex = MAXV;
`else
        ex = ex - MODV;
`endif
      end else if (ex < MINV) begin
        ov = 1;
`ifdef ACCUM_CALC_SAT_EN
        ex = MINV;
`else
        ex = ex + MODV;
`endif
      end
      a_l = ex;
      r_acc[i] = W'(a_l);
      r_ovf[i] = ov;
    end
    fin_acc = W'(a_l);
    fin_ovf = ov;
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_run = 0; m_done = 0;
      idle_acc = '0; idle_ovf = 0; idle_wrap = 0; idle_pc = '0;
    end else if (m_run) begin
      m_t++;
      if (m_t == m_end_t) begin
        m_run = 0; m_done = 1;
        idle_acc = fin_acc; idle_ovf = fin_ovf; idle_wrap = fin_wrap; idle_pc = fin_pc;
      end
    end else begin
      m_done = 0;
      if (start) begin
        model_program();
        m_run = 1; m_t = 0;
      end
    end
  end

  logic [W-1:0] e_acc;
  logic [PW-1:0] e_pc;
  logic e_busy, e_done, e_ovf, e_wrap, e_rd;
  int n_done;

  always @(negedge clk) begin
    if (m_run) begin
      n_done = m_t / 2;
      e_acc = (n_done == 0) ? '0 : r_acc[(n_done == 0) ? 0 : n_done - 1];
      e_ovf = (n_done == 0) ? 1'b0 : r_ovf[(n_done == 0) ? 0 : n_done - 1];
      e_pc = PW'(m_t / 2);
      e_busy = 1; e_done = 0; e_wrap = 0; e_rd = (m_t % 2 == 0);
    end else begin
      e_acc = idle_acc; e_ovf = idle_ovf; e_pc = idle_pc; e_wrap = idle_wrap;
      e_busy = 0; e_done = m_done; e_rd = 0;
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("acc", acc, e_acc);
    chk("zero", zero, e_acc == '0);
    chk("ovf", ovf, e_ovf);
    chk("wrapped", wrapped, e_wrap);
    chk("pc", pc, e_pc);
    chk("imem_rd_en", imem_rd_en, e_rd);
    if (e_rd) chk("imem_addr", imem_addr, e_pc);
  end

  task automatic clear_mem();
    for (int i = 0; i < D; i++) imem[i] = mk(OP_HALT, 0, 0);
  endtask

  task automatic kick();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout got no done want done within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_zero", zero, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pc", pc, 0);
    reset = 1'b1;

    // Basic program
    imem[0] = mk(OP_ADD, 5, 7); imem[1] = mk(OP_ASUB, 2, 0); imem[2] = mk(OP_HALT, 0, 0);
    kick();
    wait_done("basic", 20, cyc);
    chk("basic_cycles", cyc, 6);
    chk("basic_model_acc", fin_acc, 10);
    chk("basic_acc", acc, 10);
    chk("basic_zero", zero, 0);
    chk("basic_ovf", ovf, 0);
    chk("basic_wrapped", wrapped, 0);
    chk("basic_pc", pc, 2);

    // Overflow program
    clear_mem();
    imem[0] = mk(OP_LOAD, 8191, 0);
    for (int i = 1; i <= 4; i++) imem[i] = mk(OP_AADD, 8191, 0);
    kick();
    wait_done("ovfprog", 30, cyc);
    chk("ovfprog_cycles", cyc, 12);
    chk("ovfprog_model_acc", fin_acc, OVF_PROG_ACC);
    chk("ovfprog_acc", acc, OVF_PROG_ACC);
    chk("ovfprog_ovf", ovf, 1);

    // PC wrap
    for (int i = 0; i < D; i++) imem[i] = mk(OP_NOP, 0, 0);
    kick();
    wait_done("wrap", 40, cyc);
    chk("wrap_cycles", cyc, 2 * D);
    chk("wrap_pc", pc, 0);
    chk("wrap_wrapped", wrapped, 1);
    chk("wrap_acc", acc, 0);

    // Zero flag and negative immediates
    clear_mem();
    imem[0] = mk(OP_LOAD, 9, 0); imem[1] = mk(OP_CLR, 0, 0); imem[2] = mk(OP_SUB, 3, 3);
    imem[3] = mk(OP_SUB, -8192, 1); imem[4] = mk(OP_ADD, -8192, -8192);
    kick();
    wait_done("zeroprog", 30, cyc);
    chk("zeroprog_acc", acc, 16'hC000);
    chk("zeroprog_ovf", ovf, 0);

    // Handshake: start during busy ignored, start in done cycle accepted
    clear_mem();
    imem[0] = mk(OP_LOAD, 8191, 0);
    for (int i = 1; i <= 4; i++) imem[i] = mk(OP_AADD, 8191, 0);
    kick();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done("ign", 30, cyc);
    chk("ign_cycles", cyc + 4, 12);
    chk("ign_ovf", ovf, 1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_ovf", ovf, 0);
    chk("restart_acc", acc, 0);
    wait_done("restart", 30, cyc);
    chk("restart_cycles", cyc, 12);

    // Reset during EXEC of the third instruction
    for (int i = 0; i < D; i++) imem[i] = mk(3'($urandom_range(0, 6)), $urandom, $urandom);
    imem[0] = mk(OP_LOAD, 77, 0);
    kick();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_acc", acc, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_zero", zero, 1);
    chk("midrst_done", done, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_nodone", done, 0);

    // Random programs
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < D; i++) imem[i] = mk(3'($urandom_range(0, 7)), $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      kick();
      wait_done("rand", 2 * D + 4, cyc);
      chk("rand_cycles", cyc, m_end_t);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
